// File: rtl/hc153_tdm_demux.sv
// Time-division receiver for a dual 4-to-1 mux link: scans slot selects, captures both lanes, publishes 4-bit frames.
// Optional macro HC153_TDM_VOTE_EN: each lane bit becomes a 2-of-3 majority over the last three dwell clocks.
module hc153_tdm_demux #(
    parameter int DWELL = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic       D1,
    input  logic       D2,
    input  logic       E1N,
    input  logic       E2N,
    input  logic       ACK,
    output logic       S1,
    output logic       S2,
    output logic [0:3] Q1,
    output logic [0:3] Q2,
    output logic       FV,
    output logic       OVR,
    output logic       BUSY
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    generate
        if (DWELL < 1) begin : g_dwell_min
            $error("hc153_tdm_demux: DWELL must be at least 1");
        end
    endgenerate

    logic [0:0]    state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [1:0]    slot_r, slot_n;
    logic [0:2]    sh1_r, sh1_n, sh2_r, sh2_n;
    logic [0:3]    q1_r, q1_n, q2_r, q2_n;
    logic          fv_r, fv_n, ovr_r, ovr_n, busy_r, busy_n;
    logic          sample_s, publish_s, bit1_s, bit2_s;

    assign sample_s  = (state_r == ST_SCAN) && (cnt_r == CNT_LAST);
    assign publish_s = sample_s && (slot_r == 2'd3);

`ifdef HC153_TDM_VOTE_EN
    localparam logic [CW-1:0] CNT_VOTE0 = CW'(DWELL - 3);
    localparam logic [CW-1:0] CNT_VOTE1 = CW'(DWELL - 2);

    generate
        if (DWELL < 3) begin : g_dwell_vote
            $error("hc153_tdm_demux: DWELL must be at least 3 with majority voting");
        end
    endgenerate

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic vote1a_r, vote1b_r, vote2a_r, vote2b_r;

    // Early vote samples, taken two and one clocks ahead of the final sample.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vote1a_r <= 1'b0;
            vote1b_r <= 1'b0;
            vote2a_r <= 1'b0;
            vote2b_r <= 1'b0;
        end else if (state_r == ST_SCAN) begin
            if (cnt_r == CNT_VOTE0) begin
                vote1a_r <= D1;
                vote2a_r <= D2;
            end
            if (cnt_r == CNT_VOTE1) begin
                vote1b_r <= D1;
                vote2b_r <= D2;
            end
        end
    end

    assign bit1_s = maj3(vote1a_r, vote1b_r, D1) & ~E1N;
    assign bit2_s = maj3(vote2a_r, vote2b_r, D2) & ~E2N;
`else
    assign bit1_s = D1 & ~E1N;
    assign bit2_s = D2 & ~E2N;
`endif

    // Next-state: slot scan, shadow capture, atomic publish and handshake.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        slot_n  = slot_r;
        sh1_n   = sh1_r;
        sh2_n   = sh2_r;
        q1_n    = q1_r;
        q2_n    = q2_r;
        fv_n    = fv_r;
        ovr_n   = ovr_r;

        case (state_r)
            ST_IDLE: begin
                cnt_n  = CNT_ZERO;
                slot_n = 2'd0;
                if (RUN) begin
                    state_n = ST_SCAN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (sample_s) begin
                    cnt_n  = CNT_ZERO;
                    slot_n = slot_r + 2'd1;
                    if (publish_s && !RUN) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_SCAN;
                    end
                end else begin
                    cnt_n   = cnt_r + CNT_ONE;
                    state_n = ST_SCAN;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
                slot_n  = 2'd0;
            end
        endcase

        if (sample_s) begin
            case (slot_r)
                2'd0: begin
                    sh1_n[0] = bit1_s;
                    sh2_n[0] = bit2_s;
                end
                2'd1: begin
                    sh1_n[1] = bit1_s;
                    sh2_n[1] = bit2_s;
                end
                2'd2: begin
                    sh1_n[2] = bit1_s;
                    sh2_n[2] = bit2_s;
                end
                default: begin
                    sh1_n = sh1_r;
                    sh2_n = sh2_r;
                end
            endcase
        end else begin
            sh1_n = sh1_r;
            sh2_n = sh2_r;
        end

        // An unacknowledged frame being overwritten is the only overrun case.
        if (publish_s) begin
            q1_n = {sh1_r, bit1_s};
            q2_n = {sh2_r, bit2_s};
            fv_n = 1'b1;
            if (fv_r && !ACK) begin
                ovr_n = 1'b1;
            end else begin
                ovr_n = ovr_r;
            end
        end else if (fv_r && ACK) begin
            fv_n  = 1'b0;
            ovr_n = 1'b0;
        end else begin
            fv_n  = fv_r;
            ovr_n = ovr_r;
        end

        busy_n = (state_n == ST_SCAN);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            slot_r  <= 2'd0;
            sh1_r   <= 3'b000;
            sh2_r   <= 3'b000;
            q1_r    <= 4'b0000;
            q2_r    <= 4'b0000;
            fv_r    <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            slot_r  <= slot_n;
            sh1_r   <= sh1_n;
            sh2_r   <= sh2_n;
            q1_r    <= q1_n;
            q2_r    <= q2_n;
            fv_r    <= fv_n;
            ovr_r   <= ovr_n;
            busy_r  <= busy_n;
        end
    end

    assign S1   = slot_r[1];
    assign S2   = slot_r[0];
    assign Q1   = q1_r;
    assign Q2   = q2_r;
    assign FV   = fv_r;
    assign OVR  = ovr_r;
    assign BUSY = busy_r;

endmodule

// File: tb/tb_hc153_tdm_demux.sv
// Bench for hc153_tdm_demux: remote mux model, frame-level reference model, directed frames.
module tb_hc153_tdm_demux;

    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst, run, d1, d2, e1n, e2n, ack, glitch;
    logic s1, s2, fv, ovr, busy;
    logic [0:3] q1, q2;
    logic [0:3] i1, i2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Remote 74HC153 lanes, driven by the select outputs.
    assign d1 = glitch ? ~i1[{s1, s2}] : i1[{s1, s2}];
    assign d2 = i2[{s1, s2}];

    hc153_tdm_demux #(.DWELL(DWELL)) dut (
        .CLK(clk), .RST(rst), .RUN(run), .D1(d1), .D2(d2), .E1N(e1n), .E2N(e2n),
        .ACK(ack), .S1(s1), .S2(s2), .Q1(q1), .Q2(q2), .FV(fv), .OVR(ovr), .BUSY(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: position within the frame, captured lane bits, handshake flags.
    int         m_t;
    bit         m_busy, m_fv, m_ovr;
    logic [0:3] m_c1, m_c2, m_q1, m_q2;

    always @(posedge clk or posedge rst) begin : model
        bit pub;
        int slot;
        if (rst) begin
            m_t = 0; m_busy = 1'b0; m_fv = 1'b0; m_ovr = 1'b0;
            m_c1 = 4'b0000; m_c2 = 4'b0000; m_q1 = 4'b0000; m_q2 = 4'b0000;
        end else begin
            pub = 1'b0;
            if (!m_busy) begin
                if (run) begin
                    m_busy = 1'b1;
                    m_t = 0;
                end
            end else begin
                slot = m_t / DWELL;
                if (m_t % DWELL == DWELL - 1) begin
                    m_c1[slot] = i1[slot] & ~e1n;
                    m_c2[slot] = i2[slot] & ~e2n;
                end
                if (m_t == 4 * DWELL - 1) begin
                    pub = 1'b1;
                    m_t = 0;
                    m_busy = run;
                end else begin
                    m_t++;
                end
            end
            if (pub) begin
                if (m_fv && !ack) m_ovr = 1'b1;
                m_fv = 1'b1;
                m_q1 = m_c1;
                m_q2 = m_c2;
            end else if (m_fv && ack) begin
                m_fv = 1'b0;
                m_ovr = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("sel", {30'd0, s1, s2}, m_busy ? 32'(m_t / DWELL) : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("q1", {28'd0, q1}, {28'd0, m_q1});
            chk("q2", {28'd0, q2}, {28'd0, m_q2});
            chk("fv", {31'd0, fv}, {31'd0, m_fv});
            chk("ovr", {31'd0, ovr}, {31'd0, m_ovr});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame from the RUN-sampling edge (edge 0) through its publish edge (edge 16).
    task automatic frame(input bit keep_run);
        tick(1);
        tick(2);
        if (!keep_run) run = 1'b0;
        tick(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; run = 1'b0; ack = 1'b0; e1n = 1'b0; e2n = 1'b0; glitch = 1'b0;
        i1 = 4'b1010; i2 = 4'b0110;
        tick(2);
        rst = 1'b0;
        chk("rst_q1", {28'd0, q1}, 32'd0);
        chk("rst_fv", {31'd0, fv}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Frame 1: select sequence, publish timing, RUN dropped at edge 6.
        run = 1'b1;
        tick(1);                                   // edge 0
        chk("f1_busy_e0", {31'd0, busy}, 32'd1);
        chk("f1_sel_e0", {30'd0, s1, s2}, 32'd0);
        tick(3);                                   // edge 3
        chk("f1_sel_e3", {30'd0, s1, s2}, 32'd0);
        tick(1);                                   // edge 4
        chk("f1_sel_e4", {30'd0, s1, s2}, 32'd1);
        tick(2);                                   // edge 6
        run = 1'b0;
        tick(2);                                   // edge 8
        chk("f1_sel_e8", {30'd0, s1, s2}, 32'd2);
        tick(4);                                   // edge 12
        chk("f1_sel_e12", {30'd0, s1, s2}, 32'd3);
        tick(3);                                   // edge 15
        chk("f1_fv_e15", {31'd0, fv}, 32'd0);
        tick(1);                                   // edge 16
        chk("f1_fv", {31'd0, fv}, 32'd1);
        chk("f1_q1", {28'd0, q1}, 32'h0000000a);
        chk("f1_q2", {28'd0, q2}, 32'h00000006);
        chk("f1_ovr", {31'd0, ovr}, 32'd0);
        chk("f1_busy_e16", {31'd0, busy}, 32'd0);
        chk("model_q1", {28'd0, m_q1}, 32'h0000000a);
        tick(1);                                   // edge 17
        chk("f1_sel_e17", {30'd0, s1, s2}, 32'd0);
        ack = 1'b1;
        tick(1);
        chk("f1_ack_fv", {31'd0, fv}, 32'd0);
        ack = 1'b0;

        // Frame 2: lane 2 disabled.
        e2n = 1'b1; run = 1'b1;
        frame(1'b0);
        chk("f2_q1", {28'd0, q1}, 32'h0000000a);
        chk("f2_q2", {28'd0, q2}, 32'h00000000);
        chk("f2_ovr", {31'd0, ovr}, 32'd0);
        e2n = 1'b0;

        // Frame 3: unacknowledged frame overwritten.
        i1 = 4'b0001; run = 1'b1;
        frame(1'b0);
        chk("f3_q1", {28'd0, q1}, 32'h00000001);
        chk("f3_fv", {31'd0, fv}, 32'd1);
        chk("f3_ovr", {31'd0, ovr}, 32'd1);
        chk("model_ovr", {31'd0, m_ovr}, 32'd1);
        ack = 1'b1;
        tick(1);
        chk("f3_ack_fv", {31'd0, fv}, 32'd0);
        chk("f3_ack_ovr", {31'd0, ovr}, 32'd0);
        ack = 1'b0;

        // Frame 4 then frame 5 back to back, ACK on frame 5's publish edge.
        i1 = 4'b1011; i2 = 4'b1100; run = 1'b1;
        frame(1'b1);
        chk("f4_q1", {28'd0, q1}, 32'h0000000b);
        chk("f4_q2", {28'd0, q2}, 32'h0000000c);
        chk("f4_busy", {31'd0, busy}, 32'd1);
        chk("f4_sel", {30'd0, s1, s2}, 32'd0);
        tick(2);                                   // count 2 of slot 0
        glitch = 1'b1;
        tick(1);
        glitch = 1'b0;
        tick(1);                                   // 4 edges after publish
        chk("f5_sel_nogap", {30'd0, s1, s2}, 32'd1);
        tick(2);
        run = 1'b0;
        tick(9);
        ack = 1'b1;
        tick(1);                                   // frame 5 publish edge
        chk("f5_fv", {31'd0, fv}, 32'd1);
        chk("f5_ovr", {31'd0, ovr}, 32'd0);
        chk("f5_q1_glitch", {28'd0, q1}, 32'h0000000b);
        ack = 1'b0;

        // Asynchronous reset mid-frame.
        run = 1'b1;
        tick(6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fv", {31'd0, fv}, 32'd0);
        chk("arst_q1", {28'd0, q1}, 32'd0);
        chk("arst_q2", {28'd0, q2}, 32'd0);
        chk("arst_sel", {30'd0, s1, s2}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ovr", {31'd0, ovr}, 32'd0);
        run = 1'b0;
        rst = 1'b0;
        tick(2);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
